// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low column drive, synchronized and
// debounced row sense, one-entry valid/ack key buffer with overrun flag.
module keypad_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] KCOL,
  input  logic [3:0] KROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_e;
  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_e;

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    col_q;
  logic [1:0]    acc_cnt_q;   // lows seen so far this sweep, saturating at 2
  logic [3:0]    acc_code_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic          key_down_d;
  logic          accept;

  logic          last_dwell, sweep_end;
  logic [3:0]    col_lows;
  logic [2:0]    n_col, col_total;
  logic [1:0]    row_idx;
  logic [3:0]    col_code;
  cls_e          cls;

  assign last_dwell = (dwell_q == DWELL_LAST);
  assign sweep_end  = last_dwell && (col_q == 2'd3);
  assign col_lows   = ~sync2_q;
  assign n_col      = {2'b00, col_lows[0]} + {2'b00, col_lows[1]}
                    + {2'b00, col_lows[2]} + {2'b00, col_lows[3]};
  assign col_total  = {1'b0, acc_cnt_q} + n_col;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--)
      if (col_lows[r]) row_idx = 2'(r);
  end

  // Only meaningful when col_total == 1: the single low came earlier or now.
  assign col_code = (acc_cnt_q != 2'd0) ? acc_code_q : {row_idx, col_q};

  always_comb begin
    cls = CLS_MULTI;
    if (col_total == 3'd0)      cls = CLS_NONE;
    else if (col_total == 3'd1) cls = CLS_SINGLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 4'b1111;
      sync2_q    <= 4'b1111;
      dwell_q    <= '0;
      col_q      <= 2'd0;
      KCOL       <= 4'b1110;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
    end else begin
      sync1_q <= KROW;
      sync2_q <= sync1_q;
      if (last_dwell) begin
        dwell_q <= '0;
        col_q   <= col_q + 2'd1;
        KCOL    <= {KCOL[2:0], KCOL[3]};
        if (sweep_end) begin
          acc_cnt_q  <= 2'd0;
          acc_code_q <= 4'd0;
        end else begin
          acc_cnt_q  <= (col_total > 3'd1) ? 2'd2 : col_total[1:0];
          acc_code_q <= col_code;
        end
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    key_down_d = key_down;
    accept     = 1'b0;
    if (sweep_end) begin
      unique case (state_q)
        IDLE: begin
          if (cls == CLS_SINGLE) begin
            cand_d = col_code;
            if (DEBOUNCE_CNT == 1) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              state_d = PRESS_CHK;
              cnt_d   = CW'(1);
            end
          end
        end
        PRESS_CHK: begin
          case (cls)
            CLS_NONE: begin
              state_d = IDLE;
              cnt_d   = '0;
            end
            CLS_SINGLE: begin
              if (col_code == cand_q) begin
                if (cnt_q == DB_LAST) begin
                  accept  = 1'b1;
                  state_d = HELD;
                  cnt_d   = '0;
                end else begin
                  cnt_d = cnt_q + CW'(1);
                end
              end else begin
                cand_d = col_code;
                cnt_d  = CW'(1);
              end
            end
            default: cnt_d = '0;
          endcase
        end
        HELD: begin
          if (cls == CLS_NONE) begin
            if (DEBOUNCE_CNT == 1) begin
              state_d    = IDLE;
              key_down_d = 1'b0;
            end else begin
              state_d = RELEASE_CHK;
              cnt_d   = CW'(1);
            end
          end
        end
        RELEASE_CHK: begin
          if (cls == CLS_NONE) begin
            if (cnt_q == DB_LAST) begin
              state_d    = IDLE;
              cnt_d      = '0;
              key_down_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
      endcase
      if (accept) key_down_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cand_q    <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      key_down <= key_down_d;
      // A fresh key beats a same-cycle ack; overrun only if the old key was never taken.
      if (accept) begin
        key_code  <= cand_d;
        key_valid <= 1'b1;
        overrun   <= key_valid && !key_ack;
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule
